// File: rtl/imm_encoder_if.sv
// Handshake bundle for imm_encoder: request side (in_*) and result side (out_*).
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_src;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_imm, in_imm_src, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
  modport slave (
    input  in_valid, in_imm, in_imm_src, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into an instruction word (inverse of the core immediate extender).
// Two-stage valid/ready pipeline; optional saturating error counter under IMM_ERR_CNT_EN.
module imm_encoder (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_encoder_if.slave  bus
`ifdef IMM_ERR_CNT_EN
  ,
  output logic [15:0]   err_count
`endif
);

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  src;
    logic [31:0] base;
    logic        ok;
  } s1_t;

  s1_t         s1_q, s1_d;
  logic        s1_valid_q, s2_valid_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;
  logic        adv2, s1_ld, accept, range_ok;
  logic [31:0] pack_instr;

  assign adv2         = !s2_valid_q || bus.out_ready;
  assign s1_ld        = !s1_valid_q || adv2;
  assign bus.in_ready = !flush && s1_ld;
  assign accept       = bus.in_valid && bus.in_ready;

  // True when v >> n (arithmetic) is all zeros or all ones, i.e. v fits in n+1 signed bits.
  function automatic logic sx_fits(input logic [31:0] v, input logic [4:0] n);
    logic signed [31:0] s;
    s = $signed(v) >>> n;
    return (s == '0) || (s == '1);
  endfunction

  always_comb begin
    range_ok = 1'b0;
    case (bus.in_imm_src)
      3'b000, 3'b001: range_ok = sx_fits(bus.in_imm, 5'd11);
      3'b010:         range_ok = !bus.in_imm[0] && sx_fits(bus.in_imm, 5'd12);
      3'b011:         range_ok = !bus.in_imm[0] && sx_fits(bus.in_imm, 5'd20);
      3'b100:         range_ok = (bus.in_imm[11:0] == '0);
      3'b101:         range_ok = (bus.in_imm[31:5] == '0);
      3'b110:         range_ok = (bus.in_imm[31:12] == '0);
      default:        range_ok = 1'b0;
    endcase
  end

  always_comb begin
    s1_d.imm  = bus.in_imm;
    s1_d.src  = bus.in_imm_src;
    s1_d.base = bus.in_base;
    s1_d.ok   = range_ok;
  end

  // Overwrite only the immediate field; everything else comes from base.
  always_comb begin
    pack_instr = s1_q.base;
    case (s1_q.src)
      3'b000, 3'b110: pack_instr[31:20] = s1_q.imm[11:0];
      3'b101:         pack_instr[24:20] = s1_q.imm[4:0];
      3'b001: begin
        pack_instr[31:25] = s1_q.imm[11:5];
        pack_instr[11:7]  = s1_q.imm[4:0];
      end
      3'b010: begin
        pack_instr[31]    = s1_q.imm[12];
        pack_instr[7]     = s1_q.imm[11];
        pack_instr[30:25] = s1_q.imm[10:5];
        pack_instr[11:8]  = s1_q.imm[4:1];
      end
      3'b011: begin
        pack_instr[31]    = s1_q.imm[20];
        pack_instr[30:21] = s1_q.imm[10:1];
        pack_instr[20]    = s1_q.imm[11];
        pack_instr[19:12] = s1_q.imm[19:12];
      end
      3'b100:  pack_instr[31:12] = s1_q.imm[31:12];
      default: pack_instr = s1_q.base;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      if (flush)      s1_valid_q <= 1'b0;
      else if (s1_ld) s1_valid_q <= bus.in_valid;
      if (accept) s1_q <= s1_d;
      if (flush)     s2_valid_q <= 1'b0;
      else if (adv2) s2_valid_q <= s1_valid_q;
      // Data regs only move on advance so the output holds under backpressure.
      if (adv2 && s1_valid_q) begin
        s2_instr_q <= pack_instr;
        s2_err_q   <= !s1_q.ok;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_err   = s2_err_q;

`ifdef IMM_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt_q <= '0;
    else if (bus.out_valid && bus.out_ready && bus.out_err && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate extender: packs a 32-bit immediate into the instruction bit positions selected by ImmSrc, on top of a base instruction word that supplies all non-immediate fields.
- Used by the debug/instruction-injection path and trampoline generation to build instruction words in hardware.
- Two-stage valid/ready pipeline with range checking; flags immediates that the chosen format cannot represent.

Parameters:
- None. Widths are fixed: 32-bit data, 3-bit ImmSrc.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; drops all in-flight entries
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- in_imm  input  32  immediate value to encode
- in_imm_src  input  3  format select, same code as core ImmSrc
- in_base  input  32  instruction word providing non-immediate bits
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_instr  output  32  encoded instruction
- out_err  output  1  immediate not representable, or invalid ImmSrc
- err_count  output  16  only when IMM_ERR_CNT_EN is defined

Behaviour:
- Reset is asynchronous and active-low on rst_n; all state is clocked on clk.
- Reset values: out_valid=0, out_instr=0, out_err=0, err_count=0. Both stage valids clear. in_ready=1 after reset.
- Handshake:
  - Transfer occurs when valid&&ready.
  - adv2 = !s2_valid || out_ready.
  - in_ready = !s1_valid || adv2 (combinational, no skid).
  - Outputs are held stable while out_valid&&!out_ready.
- Latency: 2 cycles from an accepted input to out_valid, with no backpressure. Throughput is 1 per cycle. Order is preserved and no entry is lost or duplicated.
- Stage 1 registers imm, src and base, plus the range-check result ok.
- Stage 2 registers the packed instruction and err = !ok.
- Packing: start from base, then overwrite the immediate field bits listed below. All other base bits pass through unchanged.
  - 000 I: [31:20]=imm[11:0]. ok iff imm[31:11] all equal.
  - 101 shamt: [24:20]=imm[4:0]; [31:25] from base. ok iff imm[31:5]==0.
  - 001 S: [31:25]=imm[11:5], [11:7]=imm[4:0]. ok iff imm[31:11] all equal.
  - 010 B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. ok iff imm[0]==0 and imm[31:12] all equal.
  - 011 J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. ok iff imm[0]==0 and imm[31:20] all equal.
  - 100 U: [31:12]=imm[31:12]. ok iff imm[11:0]==0.
  - 110 CSR: [31:20]=imm[11:0]. ok iff imm[31:12]==0.
  - 111: out_instr=base, ok=0.
- When ok=0, the truncated packing is still emitted with out_err=1. The block never stalls or drops on error.
- Invariant: for ok=1, the core extender applied to out_instr with the same ImmSrc reproduces in_imm exactly.
- flush:
  - Clears s1_valid and s2_valid next edge. out_valid=0 next cycle.
  - Any in_valid in the flush cycle is not accepted; in_ready=0 during flush.
  - err_count is not affected.
- Simultaneous accept and emit in one cycle with a full pipeline is legal and sustains throughput.
- Reset asserted mid-operation discards everything immediately (asynchronous), regardless of handshake state.

Optional Feature:
- Macro: IMM_ERR_CNT_EN.
- Defined:
  - err_count port exists and is a 16-bit saturating counter.
  - Increments once per output transfer (out_valid&&out_ready) with out_err=1.
  - Holds at 0xFFFF once reached.
  - Reset to 0 by rst_n only.
- Undefined: no err_count port and no counter logic. All other behaviour is identical.

Test Plan:
- I-type: imm=0xFFFFFFFF, src=000, base=0x00000013 -> out_instr=0xFFF00013, err=0, 2 cycles after accept.
- B-type: imm=0x00000800, src=010, base=0x00000063 -> 0x000000E3, err=0. Same with imm=0x00000801 -> err=1.
- U-type: imm=0x12345000, src=100, base=0x00000037 -> 0x12345037, err=0. Same with imm=0x12345001 -> 0x12345037, err=1. With IMM_ERR_CNT_EN defined, err_count=1 after that transfer.
- Backpressure:
  - Stimulus: feed 4 back-to-back requests with out_ready=0.
  - in_ready falls after 2 accepts.
  - Raise out_ready: all 4 emerge in order, one per cycle, with no duplicates.
- Flush/reset: with 2 entries in flight, pulse flush -> out_valid=0 next cycle, neither entry is emitted. Repeat using rst_n low mid-transfer -> outputs go to reset values immediately.
- Random round-trip: 10k random imm/src/base values, checked against the extender model for all ok=1 cases and against the range rules for err.
